// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and defaults for the UART receive path
package uart_pkg;

   localparam int UART_FIFO_DEPTH_LOG2  = 4;
   localparam int UART_FIFO_ALMOST_FULL = 12;

   typedef enum logic {
      ING_IDLE = 1'b0,
      ING_ACK  = 1'b1
   } ing_state_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with registered level/flags
module sync_fifo_fwft #(
   parameter int DEPTH_LOG2  = 4,
   parameter int ALMOST_FULL = 12,
   parameter int WIDTH       = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [WIDTH-1:0]      din,
   input  logic                  pop,
   output logic [WIDTH-1:0]      dout,
   output logic                  not_empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int                  DEPTH   = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LVL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LVL_AF  = (DEPTH_LOG2 + 1)'(ALMOST_FULL);
   localparam logic [DEPTH_LOG2:0] LVL_ONE = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level_next;
   logic                  wr_en;
   logic                  rd_en;

   // Gate on the registered flags: a write while full is refused even if a pop frees a slot this cycle.
   assign wr_en = push && !full;
   assign rd_en = pop && not_empty;
   assign dout  = mem[rd_ptr];

   always_comb begin
      level_next = level;
      case ({wr_en, rd_en})
         2'b10:   level_next = level + LVL_ONE;
         2'b01:   level_next = level - LVL_ONE;
         default: level_next = level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         not_empty   <= 1'b0;
         full        <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         level       <= level_next;
         not_empty   <= (level_next != '0);
         full        <= (level_next == LVL_MAX);
         almost_full <= (level_next >= LVL_AF);
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - drains uart_rx bytes with a data_read handshake into a FWFT FIFO
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2  = UART_FIFO_DEPTH_LOG2,
   parameter int ALMOST_FULL = UART_FIFO_ALMOST_FULL
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rxdata_in,
   input  logic                  rxrecv_in,
   output logic                  data_read_out,
   input  logic                  cpu_rd,
   output logic [7:0]            cpu_dout,
   output logic                  not_empty,
   output logic                  full,
   output logic                  almost_full,
   output logic [DEPTH_LOG2:0]   level
);

   ing_state_t state_q;
   ing_state_t state_d;
   logic       push;

   // ACK waits for rxrecv to drop so a byte still held after its ack is not written twice.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         ING_IDLE: begin
            if (rxrecv_in && !full) begin
               push    = 1'b1;
               state_d = ING_ACK;
            end
         end
         ING_ACK: begin
            if (!rxrecv_in) begin
               state_d = ING_IDLE;
            end
         end
         default: state_d = ING_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ING_IDLE;
         data_read_out <= 1'b0;
      end else begin
         state_q       <= state_d;
         data_read_out <= push;
      end
   end

   sync_fifo_fwft #(
      .DEPTH_LOG2  (DEPTH_LOG2),
      .ALMOST_FULL (ALMOST_FULL),
      .WIDTH       (8)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push),
      .din         (rxdata_in),
      .pop         (cpu_rd),
      .dout        (cpu_dout),
      .not_empty   (not_empty),
      .full        (full),
      .almost_full (almost_full),
      .level       (level)
   );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Downstream of uart_rx: drains each received byte (rxrecv/rxdata), acks it with a one-cycle data_read pulse, and buffers it in a first-word-fall-through FIFO for the CPU port logic.
- While the FIFO is full it withholds the ack. uart_rx then stays in WAIT with rts high, so flow control reaches the remote end and no byte is lost.
- Runs in the 28 MHz clk domain alongside uart_rx.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries (16).
- ALMOST_FULL, 12: almost_full asserts when level >= ALMOST_FULL. Legal range 1..2**DEPTH_LOG2.

Ports:
- clk  in  1  system clock, 28 MHz; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- rxdata_in  in  8  byte from uart_rx (rxdata).
- rxrecv_in  in  1  byte-valid from uart_rx (rxrecv); level signal, held until acked.
- data_read_out  out  1  ack to uart_rx (data_read); one-cycle pulse.
- cpu_rd  in  1  pop request; one clk per byte.
- cpu_dout  out  8  head-of-FIFO byte; valid when not_empty.
- not_empty  out  1  FIFO holds at least 1 byte.
- full  out  1  level == 2**DEPTH_LOG2.
- almost_full  out  1  level >= ALMOST_FULL.
- level  out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2.

Behaviour:
- Reset values: rd/wr pointers 0, level 0, not_empty 0, full 0, almost_full 0, data_read_out 0, ingress FSM in IDLE. Storage is not cleared; cpu_dout is don't-care while empty.
- Ingress FSM has states IDLE and ACK.
  - IDLE: if rxrecv_in==1 and full==0, write rxdata_in at wr_ptr, increment wr_ptr, drive data_read_out=1 for exactly this cycle, go to ACK. If full==1, stay in IDLE with data_read_out=0; the byte is held upstream.
  - ACK: no writes. Go to IDLE on the first cycle rxrecv_in==0. This is required because uart_rx keeps rxrecv high for one or more cycles after the ack; without it the same byte would be written twice.
- Full is registered. A pop and a write request in the same cycle while full: the pop completes and the write is refused that cycle, then accepted the next cycle. There is no pass-through.
- Egress: cpu_dout = mem[rd_ptr], first-word-fall-through. Storage may be inferred as distributed RAM or registers.
  - cpu_rd==1 with not_empty==1: increment rd_ptr; the next byte appears on cpu_dout on the following cycle.
  - cpu_rd==1 with empty: ignored; pointers and flags unchanged.
- Level arithmetic:
  - write only: +1.
  - pop only: -1.
  - write and pop in the same cycle: unchanged (both pointers advance).
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth. Full/empty are derived from level, never from pointer equality.
- All flags are registered and reflect level after the current cycle's update. There is no combinational path from inputs to outputs except cpu_dout from rd_ptr.
- Latency: a byte accepted in cycle N is visible on cpu_dout and not_empty in cycle N+1, if the FIFO was empty.
- Reset mid-operation (FIFO contents or ACK state): everything clears. If uart_rx is still holding rxrecv high after reset, that byte is accepted as a fresh byte. Bytes already buffered are lost; this is intentional.

Decomposition:
- Shared package uart_pkg holds the ingress state encodings (ING_IDLE, ING_ACK) and defaults UART_FIFO_DEPTH_LOG2=4 and UART_FIFO_ALMOST_FULL=12.
- One natural sub-module: sync_fifo_fwft, holding storage, pointers and level with push/pop/full/empty/level. uart_rx_fifo keeps only the ingress handshake FSM.

Test Plan:
- Single byte: rxrecv_in held high with rxdata_in=8'hA5 until 2 cycles after the ack -> exactly one data_read_out pulse, level=1, cpu_dout=8'hA5. Then cpu_rd pulse -> not_empty=0, level=0.
- Fill and backpressure: 17 bytes 8'h00..8'h10, each held until acked -> 16 acks, full=1, almost_full asserted at level 12, 17th byte not acked. One cpu_rd -> 17th byte acked within 2 cycles, level=16.
- Ordering and wrap: 40 bytes with interleaved pops; read data matches 0..39 in order; pointers wrap twice; level never exceeds 16.
- Simultaneous push and pop at level 5 -> level stays 5; cpu_dout advances to the next byte.
- Pop on empty: cpu_rd=1 for 3 cycles at reset state -> level=0, no pointer movement. The next byte written reads back correctly.
- Reset in ACK state with rxrecv_in still high and 3 bytes buffered -> level=0 after reset, then the held byte is accepted once (level=1, one ack pulse).
